// File: rtl/gcd_bcd_conv_if.sv
// Handshake bundle for the GCD-result to BCD conversion stage.
//
// Valid/ready rule (both sides): a transfer happens at a rising clk edge where
// valid and ready are both 1. The source holds valid and data steady until that
// edge. The sink may raise or lower ready at any time.
// On the output side, out_bcd is only meaningful while out_valid is 1.
interface gcd_bcd_conv_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;

  // Producer/consumer side (the bench, or GCD core plus display logic).
  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd
  );

  // Converter side.
  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd
  );
endinterface

// File: rtl/gcd_bcd_conv.sv
// Binary to packed-BCD converter stage that sits after the GCD unit.
// It uses sequential double-dabble and handles one input bit per clock.
// A finished result stays buffered in out_bcd until the consumer takes it.
// When a new input arrives in the same cycle that the old result leaves,
// the stage goes straight back into conversion.
module gcd_bcd_conv #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  gcd_bcd_conv_if.slave       bus,
  output logic [1:0]          dbg_state
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // The accumulator must be able to hold the largest binary input.
  if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_param_check
    $error("gcd_bcd_conv: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     bcd_q, bcd_d;

  logic [AW-1:0]     adj_acc;
  logic [AW-1:0]     acc_shifted;
  logic              in_ready_c;
  logic              out_valid_c;

  // Add 3 to every digit that is 5 or more. All digits are adjusted in
  // parallel, and no carry passes from one digit to the next.
  always_comb begin
    adj_acc = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj_acc[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift the next binary MSB into the adjusted accumulator. The accumulator
  // MSB falls off the top; the DIGITS bound guarantees it is always 0.
  assign acc_shifted = {adj_acc[AW-2:0], sh_q[WIDTH-1]};

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    bcd_d       = bcd_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          sh_d    = bus.in_bin;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CONV;
        end
      end

      CONV: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        acc_d = acc_shifted;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = acc_shifted;
          state_d = HOLD;
        end
      end

      HOLD: begin
        out_valid_c = 1'b1;
        // A slot opens exactly when the buffered result is being taken.
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            sh_d    = bus.in_bin;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = CONV;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any partial conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.in_ready  = in_ready_c & ~rst;
  assign bus.out_valid = out_valid_c;
  assign bus.out_bcd   = bcd_q;
  assign dbg_state     = state_q;

endmodule
